// File: rtl/fpu_pkg.sv
// FPU shared types: unrounded results, packed floats, exception flags.
// Also holds the rounding-increment and leading-zero helpers.
package fpu_pkg;

    typedef enum logic [1:0] {
        FPU_RM_EVEN = 2'd0,
        FPU_RM_ZERO = 2'd1,
        FPU_RM_DOWN = 2'd2,
        FPU_RM_UP   = 2'd3
    } fpu_rmode_e;

    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [2:0]  guard;
        logic [7:0]  exponent;
        logic [23:0] mantissa;
        fpu_rmode_e  mode;
    } fpu_result_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fpu_float_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fpu_flags_t;

    localparam logic [31:0] FPU_FLOAT_NAN     = 32'hFFFF_FFFF;
    localparam logic [31:0] FPU_FLOAT_MAX_POS = 32'h7F7F_FFFF;
    localparam logic [31:0] FPU_FLOAT_MAX_NEG = 32'hFF7F_FFFF;

    // guard is {g, r, s}
    function automatic logic fpu_round_increment(
        input fpu_rmode_e mode,
        input logic       sign,
        input logic       lsb,
        input logic [2:0] guard
    );
        logic inexact;
        logic inc;
        inexact = |guard;
        unique case (mode)
            FPU_RM_EVEN: inc = guard[2] & (guard[1] | guard[0] | lsb);
            FPU_RM_ZERO: inc = 1'b0;
            FPU_RM_DOWN: inc = inexact & sign;
            FPU_RM_UP:   inc = inexact & ~sign;
            default:     inc = 1'b0;
        endcase
        return inc;
    endfunction

    function automatic logic [4:0] fpu_lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       done;
        n    = 5'd0;
        done = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!done && !v[i]) n = n + 5'd1;
            else done = 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_round_normalize.sv
// Stage-1 normalize: left-justify the mantissa without dropping
// below exponent 1, marking leftovers as denormal (exponent 0).
module fpu_round_normalize
    import fpu_pkg::*;
(
    input  fpu_result_t res,
    output fpu_result_t norm
);

    logic [4:0]  lz;
    logic [7:0]  lim;
    logic [7:0]  sh;
    logic [25:0] wide;
    logic [25:0] shifted;
    logic        do_norm;

    always_comb begin
        norm    = res;
        lz      = fpu_lzc24(res.mantissa);
        lim     = res.exponent - 8'd1;
        sh      = ({3'b0, lz} < lim) ? {3'b0, lz} : lim;
        wide    = {res.mantissa, res.guard[2:1]};
        shifted = wide << sh;
        do_norm = !res.mantissa[23] && (res.exponent > 8'd1);
        // sticky bit never moves; g and r shift into the mantissa
        if (do_norm) begin
            norm.mantissa = shifted[25:2];
            norm.guard    = {shifted[1:0], res.guard[0]};
            norm.exponent = res.exponent - sh;
        end
        if (norm.exponent == 8'd1 && !norm.mantissa[23])
            norm.exponent = 8'd0;
    end

endmodule

// File: rtl/fpu_round_stage.sv
// Two-stage normalize/round/pack of unrounded FPU results into
// IEEE-754 single with flags, valid/ready on both sides.
module fpu_round_stage
    import fpu_pkg::*;
#(
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  fpu_result_t          in_result,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output fpu_float_t           out_float,
    output fpu_flags_t           out_flags,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_adv;
    logic                 s2_adv;
    fpu_result_t          s1_res;
    fpu_result_t          norm;
    logic [TAG_WIDTH-1:0] s1_tag;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    fpu_round_normalize u_norm (
        .res  (in_result),
        .norm (norm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_res <= norm;
                s1_tag <= in_tag;
            end
        end
    end

    logic       inc;
    logic       inexact;
    logic       ovf;
    logic       to_inf;
    logic [24:0] m25;
    logic [8:0]  e9;
    fpu_float_t  rnd_float;
    fpu_flags_t  rnd_flags;

    always_comb begin
        inexact = |s1_res.guard;
        inc = fpu_round_increment(s1_res.mode, s1_res.sign,
                                  s1_res.mantissa[0], s1_res.guard);
        m25 = {1'b0, s1_res.mantissa} + {24'd0, inc};
        e9  = {1'b0, s1_res.exponent};
        if (m25[24]) begin
            m25 = m25 >> 1;
            e9  = e9 + 9'd1;
        end else if (e9 == 9'd0 && m25[23]) begin
            e9 = 9'd1;
        end
        ovf    = e9 >= 9'd255;
        to_inf = (s1_res.mode == FPU_RM_EVEN)
               | (s1_res.mode == FPU_RM_UP   & ~s1_res.sign)
               | (s1_res.mode == FPU_RM_DOWN &  s1_res.sign);
        rnd_float = '{sign: s1_res.sign, exponent: e9[7:0],
                      mantissa: m25[22:0]};
        rnd_flags    = '0;
        rnd_flags.of = ovf;
        rnd_flags.nx = inexact | ovf;
        rnd_flags.uf = (e9 == 9'd0) & (inexact | ovf);
        priority case (1'b1)
            s1_res.nan: begin
                rnd_float = FPU_FLOAT_NAN;
                rnd_flags = '0;
            end
            s1_res.inf: begin
                rnd_float = '{sign: s1_res.sign, exponent: 8'hFF,
                              mantissa: 23'd0};
                rnd_flags = '0;
            end
            s1_res.zero: begin
                rnd_float = '{sign: s1_res.sign, exponent: 8'h00,
                              mantissa: 23'd0};
                rnd_flags = '0;
            end
            ovf: begin
                if (to_inf)
                    rnd_float = '{sign: s1_res.sign, exponent: 8'hFF,
                                  mantissa: 23'd0};
                else
                    rnd_float = s1_res.sign ? FPU_FLOAT_MAX_NEG
                                            : FPU_FLOAT_MAX_POS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_float <= '0;
            out_flags <= '0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_float <= rnd_float;
                out_flags <= rnd_flags;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule
